// File: rtl/maze_solver_if.sv
// Memory-side bus of the maze solver: address, write data, three one-cycle
// strobes and the read data returned by the 16x16 single-bit maze memory.
interface maze_solver_if;
    logic [7:0] mem_loc;
    logic       mem_din;
    logic       mem_en;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_dout;

    // Solver drives the request side and consumes read data.
    modport master (
        output mem_loc, mem_din, mem_en, mem_rd, mem_wr,
        input  mem_dout
    );

    // Maze memory answers requests.
    modport slave (
        input  mem_loc, mem_din, mem_en, mem_rd, mem_wr,
        output mem_dout
    );
endinterface

// File: rtl/maze_solver.sv
// Depth-first maze solver: walks from (0,0) toward (GOAL_X,GOAL_Y) over a
// 16x16 single-bit maze memory, marking visited cells with 1 and keeping the
// path as a stack of 2-bit directions. Every output is registered; strobes
// are decoded from the next state so each is high for exactly its state.
module maze_solver #(
    parameter logic [3:0] GOAL_X = 4'd15,
    parameter logic [3:0] GOAL_Y = 4'd15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    maze_solver_if.master        mem,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [8:0]           path_len,
    output logic                 move_valid,
    output logic [1:0]           move_dir,
    output logic                 move_back
);

    typedef enum logic [3:0] {
        IDLE, LOAD, LD_WAIT, S_RD, S_WAIT, MARK, CHECK,
        RD_REQ, RD_WAIT, PUSH, POP, DONE, FAIL
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  pos_x, pos_y, pos_x_nx, pos_y_nx;
    logic [2:0]  dir, dir_nx;          // bit 2 set means all four directions tried
    logic [8:0]  sp, sp_nx;
    logic [1:0]  stack [256];
    logic        push_en;
    logic [7:0]  sp_top;
    logic [1:0]  top_dir;

    logic [3:0]  nb_x, nb_y;
    logic        nb_oob;

    logic [7:0]  loc_nx;
    logic        en_nx, rd_nx, wr_nx, busy_nx, done_nx, fail_nx;
    logic        mv_nx, mback_nx;
    logic [1:0]  mdir_nx;

    assign mem.mem_din = 1'b1;        // the only value ever written is the visited mark
    assign path_len    = sp;
    assign sp_top      = sp[7:0] - 8'd1;
    assign top_dir     = stack[sp_top];

    // Neighbour of the current cell in direction dir, with edge detection.
    always_comb begin
        nb_x   = pos_x;
        nb_y   = pos_y;
        nb_oob = 1'b0;
        case (dir[1:0])
            2'd0: begin nb_x = pos_x + 4'd1; nb_oob = (pos_x == 4'd15); end
            2'd1: begin nb_y = pos_y + 4'd1; nb_oob = (pos_y == 4'd15); end
            2'd2: begin nb_x = pos_x - 4'd1; nb_oob = (pos_x == 4'd0);  end
            2'd3: begin nb_y = pos_y - 4'd1; nb_oob = (pos_y == 4'd0);  end
        endcase
    end

    // Next state, datapath updates and the registered-output values for the next cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_nx = state;
        pos_x_nx = pos_x;
        pos_y_nx = pos_y;
        dir_nx   = dir;
        sp_nx    = sp;
        push_en  = 1'b0;
        done_nx  = done;
        fail_nx  = fail;
        loc_nx   = mem.mem_loc;
        en_nx    = 1'b0;
        rd_nx    = 1'b0;
        wr_nx    = 1'b0;
        mv_nx    = 1'b0;
        mdir_nx  = move_dir;
        mback_nx = move_back;

        case (state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    state_nx = LOAD;
                    done_nx  = 1'b0;
                    fail_nx  = 1'b0;
                    sp_nx    = 9'd0;
                    pos_x_nx = 4'd0;
                    pos_y_nx = 4'd0;
                end
            end
            LOAD:    state_nx = LD_WAIT;
            LD_WAIT: state_nx = S_RD;
            S_RD:    state_nx = S_WAIT;
            S_WAIT: begin
                if (mem.mem_dout) begin
                    fail_nx  = 1'b1;
                    state_nx = FAIL;
                end else if (pos_x == GOAL_X && pos_y == GOAL_Y) begin
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end else begin
                    state_nx = MARK;
                end
            end
            MARK: begin
                dir_nx   = 3'd0;
                state_nx = CHECK;
            end
            CHECK: begin
                if (dir[2])      state_nx = POP;
                else if (nb_oob) dir_nx   = dir + 3'd1;
                else             state_nx = RD_REQ;
            end
            RD_REQ: state_nx = RD_WAIT;
            RD_WAIT: begin
                if (mem.mem_dout) begin
                    dir_nx   = dir + 3'd1;
                    state_nx = CHECK;
                end else begin
                    state_nx = PUSH;
                end
            end
            PUSH: begin
                push_en  = 1'b1;
                sp_nx    = sp + 9'd1;
                pos_x_nx = nb_x;
                pos_y_nx = nb_y;
                if (nb_x == GOAL_X && nb_y == GOAL_Y) begin
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end else begin
                    state_nx = MARK;
                end
            end
            POP: begin
                if (sp == 9'd0) begin
                    fail_nx  = 1'b1;
                    state_nx = FAIL;
                end else begin
                    sp_nx = sp - 9'd1;
                    case (top_dir)
                        2'd0: pos_x_nx = pos_x - 4'd1;
                        2'd1: pos_y_nx = pos_y - 4'd1;
                        2'd2: pos_x_nx = pos_x + 4'd1;
                        2'd3: pos_y_nx = pos_y + 4'd1;
                    endcase
                    dir_nx   = {1'b0, top_dir} + 3'd1;
                    state_nx = CHECK;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Outputs that belong to the state being entered.
        case (state_nx)
            LOAD:   en_nx = 1'b1;
            S_RD:   begin rd_nx = 1'b1; loc_nx = 8'h00; end
            MARK:   begin wr_nx = 1'b1; loc_nx = {pos_x_nx, pos_y_nx}; end
            // Entered only from CHECK, where pos and dir are unchanged.
            RD_REQ: begin rd_nx = 1'b1; loc_nx = {nb_x, nb_y}; end
            // Entered only from RD_WAIT, where dir is unchanged.
            PUSH:   begin mv_nx = 1'b1; mdir_nx = dir[1:0]; mback_nx = 1'b0; end
            // Entered only from CHECK, so sp still addresses the top entry.
            POP: begin
                if (sp != 9'd0) begin
                    mv_nx    = 1'b1;
                    mdir_nx  = top_dir ^ 2'd2;
                    mback_nx = 1'b1;
                end
            end
            default: ;
        endcase
        busy_nx = !(state_nx == IDLE || state_nx == DONE || state_nx == FAIL);
    end

    // State, position, stack pointer and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pos_x       <= 4'd0;
            pos_y       <= 4'd0;
            dir         <= 3'd0;
            sp          <= 9'd0;
            mem.mem_loc <= 8'h00;
            mem.mem_en  <= 1'b0;
            mem.mem_rd  <= 1'b0;
            mem.mem_wr  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            move_valid  <= 1'b0;
            move_dir    <= 2'd0;
            move_back   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_nx;
            pos_x       <= pos_x_nx;
            pos_y       <= pos_y_nx;
            dir         <= dir_nx;
            sp          <= sp_nx;
            mem.mem_loc <= loc_nx;
            mem.mem_en  <= en_nx;
            mem.mem_rd  <= rd_nx;
            mem.mem_wr  <= wr_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            fail        <= fail_nx;
            move_valid  <= mv_nx;
            move_dir    <= mdir_nx;
            move_back   <= mback_nx;
        end
    end

    // Direction stack write on each forward step.
    always_ff @(posedge clk) begin
        // NOTE: the stack is not reset; entries above sp are never read.
        if (push_en) stack[sp[7:0]] <= dir[1:0];
    end

endmodule

// File: doc/maze_solver.md
Name: maze_solver

Overview:
- Requester-side controller for the 16x16 single-bit maze memory; drives its loc/dIn/en/rd/wr and consumes dOut.
- Runs a depth-first search from cell (0,0) to cell (15,15), treating a cell value of 1 as blocked and marking visited cells by writing 1.
- Keeps the current path on an internal direction stack and reports each move so downstream logic can trace or display the route.

Parameters:
- GOAL_X, 15, goal row (0..15)
- GOAL_Y, 15, goal column (0..15)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a solve; sampled only in IDLE, DONE or FAIL
- mem_loc  output  8  maze address, {x[3:0], y[3:0]}; x = row, y = column
- mem_din  output  1  write data to memory; always 1 (visited mark)
- mem_en  output  1  map-reload strobe, one cycle
- mem_rd  output  1  read strobe, one cycle
- mem_wr  output  1  write strobe, one cycle
- mem_dout  input  1  read data; valid in the cycle after the edge that sampled mem_rd=1
- busy  output  1  high from LOAD through the last search state
- done  output  1  goal reached; held until next start or reset
- fail  output  1  no path exists; held until next start or reset
- path_len  output  9  current stack depth (0..256)
- move_valid  output  1  one-cycle pulse per position change
- move_dir  output  2  direction of the move: 0 x+1, 1 y+1, 2 x-1, 3 y-1
- move_back  output  1  with move_valid: 1 = backtrack step, 0 = forward push

Behaviour:
- Reset: state IDLE; pos (0,0); sp 0; dir 0; all outputs 0 except mem_din = 1.
- Async assertion mid-solve aborts immediately; no memory strobes are issued while rst_n = 0.
- All outputs are registered. A strobe asserted for a state is high for exactly that state's single cycle.
- States and transitions:
  - IDLE: on start, clear done/fail/sp, pos = (0,0), go to LOAD.
  - LOAD: mem_en = 1, then go to LD_WAIT.
  - LD_WAIT: one idle cycle, then go to S_RD.
  - S_RD: mem_rd = 1 at (0,0), then go to S_WAIT.
  - S_WAIT: sample mem_dout. If 1, set fail and go to FAIL. If 0 and the start cell is the goal, go to DONE. Otherwise go to MARK.
  - MARK: mem_wr = 1 at pos, dir = 0, then go to CHECK.
  - CHECK:
    - If dir has wrapped past 3 (4 tried, tracked by a 3-bit counter), go to POP.
    - Otherwise form the neighbour. If it is out of 0..15, dir++ and stay in CHECK with no memory access.
    - Otherwise go to RD_REQ.
  - RD_REQ: mem_rd = 1, mem_loc = neighbour, then go to RD_WAIT.
  - RD_WAIT: sample mem_dout. If 1, dir++ and go to CHECK. If 0, go to PUSH.
  - PUSH:
    - stack[sp] = dir; sp++; pos = neighbour.
    - Pulse move_valid with move_dir = dir and move_back = 0.
    - If the new pos is the goal, go to DONE; else go to MARK.
  - POP:
    - If sp == 0, set fail and go to FAIL.
    - Else sp--, d = stack[sp], pos moves opposite to d.
    - Pulse move_valid with move_dir = d^2 and move_back = 1.
    - dir = d+1 (resume with the next direction), then go to CHECK.
  - DONE / FAIL: outputs held; start returns to LOAD.
- Stack: 256 x 2 bits; sp is 9 bits. sp cannot exceed 255 because cells are marked before being pushed.
- Goal cell is never written. All other visited cells stay marked after the solve.
- start while busy is ignored.
- Forward step into a free cell costs 5 cycles: CHECK, RD_REQ, RD_WAIT, PUSH, MARK.
- Blocked neighbour costs 3 cycles; out-of-bounds neighbour costs 1 cycle.

Test Plan:
- Empty map (all 0), start -> first 15 moves dir 0 (x+1) down column 0, then 15 moves dir 1 along row 15; done=1, path_len=30, fail=0, no move_back.
- map[0][0]=1 -> exactly one mem_rd at loc 0x00, then fail=1, path_len=0, zero mem_wr and zero move_valid pulses.
- Column 0 open to (5,0) with (6,0), (5,1) and all other cells of rows 1..5 blocked except column 0, and (0,1) open onward -> 5 forward moves, 5 backtrack pulses with move_dir=2, then search resumes east from (0,0); path_len returns to 0 before climbing.
- Goal enclosed by 1s -> every reachable cell written once, fail=1, path_len=0, busy=0.
- rst_n low during RD_WAIT -> all strobes 0 in the same cycle, busy=0, path_len=0, pos (0,0). A subsequent start reissues mem_en before any mem_rd.
- start pulsed repeatedly while busy -> no extra mem_en; move sequence is identical to the single-start run.
